// File: rtl/uart_frame_scheduler.sv
// Round-robin scheduler that shares one two-byte serial frame transmitter among
// NREQ sources, holding each frame's data and enforcing frame length plus gap.
module uart_frame_scheduler #(
    parameter int NREQ       = 4,
    parameter int FRAME_BITS = 19,
    parameter int GAP        = 2
) (
    input  logic                      clk_1M,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [8*NREQ-1:0]         req_a_data,
    input  logic [8*NREQ-1:0]         req_b_data,
    input  logic                      clr_ovr,
    output logic                      tx_start,
    output logic [7:0]                tx_a_data,
    output logic [7:0]                tx_b_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic [NREQ-1:0]           overrun
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(FRAME_BITS + GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [IDW-1:0]  r_last;
    logic [NREQ-1:0] r_pending;
    logic [7:0]      r_slot_a [NREQ];
    logic [7:0]      r_slot_b [NREQ];

    logic            w_found;
    logic [IDW-1:0]  w_pick;
    logic            w_grant;
    logic [NREQ-1:0] w_grant_mask;

    // Round-robin search: sources above the last grant first, then wrap to the bottom.
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && r_pending[i] && (i > int'(r_last))) begin
                w_found = 1'b1;
                w_pick  = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && r_pending[i] && (i <= int'(r_last))) begin
                w_found = 1'b1;
                w_pick  = IDW'(i);
            end
        end
    end

    assign w_grant      = (r_state == S_IDLE) && w_found;
    assign w_grant_mask = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_pick) : '0;

    // A request landing on its own grant edge refills the slot without an overrun.
    // NOTE: the slot memories are reset explicitly so a stray grant can never emit stale data.
    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            overrun   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_slot_a[i] <= '0;
                r_slot_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    r_slot_a[i] <= req_a_data[8*i +: 8];
                    r_slot_b[i] <= req_b_data[8*i +: 8];
                end
            end
            r_pending <= (r_pending & ~w_grant_mask) | req;
            overrun   <= (clr_ovr ? '0 : overrun) | (req & r_pending & ~w_grant_mask);
        end
    end

    // NOTE: state is updated with non-blocking assignments so the grant reads pre-edge slot data.
    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= IDW'(NREQ - 1);
            tx_start  <= 1'b0;
            tx_a_data <= '0;
            tx_b_data <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        tx_a_data <= r_slot_a[w_pick];
                        tx_b_data <= r_slot_b[w_pick];
                        grant_id  <= w_pick;
                        r_last    <= w_pick;
                        busy      <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    tx_start <= 1'b1;
                    r_cnt    <= CW'(FRAME_BITS - 1);
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (GAP > 0) begin
                            r_cnt   <= CW'(GAP - 1);
                            r_state <= S_GAP;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: a timeline model of grants checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_frame_scheduler;

    localparam int NREQ       = 4;
    localparam int FRAME_BITS = 19;
    localparam int GAP        = 2;
    localparam int PERIOD     = FRAME_BITS + GAP + 2;

    logic              clk_1M = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_a_data = '0;
    logic [8*NREQ-1:0] req_b_data = '0;
    logic              clr_ovr = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_a_data;
    logic [7:0]        tx_b_data;
    logic [1:0]        grant_id;
    logic              busy;
    logic [NREQ-1:0]   overrun;

    uart_frame_scheduler #(.NREQ(NREQ), .FRAME_BITS(FRAME_BITS), .GAP(GAP)) dut (
        .clk_1M     (clk_1M),
        .rst        (rst),
        .req        (req),
        .req_a_data (req_a_data),
        .req_b_data (req_b_data),
        .clr_ovr    (clr_ovr),
        .tx_start   (tx_start),
        .tx_a_data  (tx_a_data),
        .tx_b_data  (tx_b_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk_1M = ~clk_1M;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: a grant happens at the first edge where the line is free and
    // something is pending; the line is then occupied for PERIOD edges.
    int              ecnt = 0;
    bit              m_pend [NREQ];
    logic [7:0]      m_sa [NREQ];
    logic [7:0]      m_sb [NREQ];
    int              m_last, m_free, m_gedge, m_id, m_g, m_idx;
    logic [7:0]      m_a, m_b;
    logic [NREQ-1:0] m_ovr;

    always @(posedge clk_1M) begin
        ecnt++;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                m_pend[i] = 1'b0;
                m_sa[i]   = 8'h00;
                m_sb[i]   = 8'h00;
            end
            m_last  = NREQ - 1;
            m_free  = 0;
            m_gedge = -1000;
            m_id    = 0;
            m_a     = 8'h00;
            m_b     = 8'h00;
            m_ovr   = '0;
        end else begin
            m_g = -1;
            if (ecnt >= m_free) begin
                for (int j = 1; j <= NREQ; j++) begin
                    m_idx = (m_last + j) % NREQ;
                    if (m_g < 0 && m_pend[m_idx]) m_g = m_idx;
                end
            end
            if (m_g >= 0) begin
                m_a       = m_sa[m_g];
                m_b       = m_sb[m_g];
                m_id      = m_g;
                m_last    = m_g;
                m_gedge   = ecnt;
                m_free    = ecnt + PERIOD;
                m_pend[m_g] = 1'b0;
            end
            if (clr_ovr) m_ovr = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (m_pend[i]) m_ovr[i] = 1'b1;
                    m_pend[i] = 1'b1;
                    m_sa[i]   = req_a_data[8*i +: 8];
                    m_sb[i]   = req_b_data[8*i +: 8];
                end
            end
        end
    end

    int s_edge[$];
    int s_id[$];
    int s_a[$];
    int s_b[$];
    int busy_cnt = 0;

    always @(negedge clk_1M) begin
        if (rst) begin
            check("tx_start", 32'(tx_start), 32'(ecnt == m_gedge + 1));
            check("busy", 32'(busy), 32'((ecnt >= m_gedge) && (ecnt <= m_gedge + FRAME_BITS + GAP)));
            check("tx_a_data", 32'(tx_a_data), 32'(m_a));
            check("tx_b_data", 32'(tx_b_data), 32'(m_b));
            check("grant_id", 32'(grant_id), 32'(m_id));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (tx_start) begin
                s_edge.push_back(ecnt);
                s_id.push_back(int'(grant_id));
                s_a.push_back(int'(tx_a_data));
                s_b.push_back(int'(tx_b_data));
            end
            if (busy) busy_cnt++;
        end
    end

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_1M);
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] a,
                         input logic [8*NREQ-1:0] b, output int k);
        @(negedge clk_1M);
        req = r;
        req_a_data = a;
        req_b_data = b;
        k = ecnt + 1;
        @(negedge clk_1M);
        req = '0;
    endtask

    task automatic do_reset();
        @(posedge clk_1M);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk_1M);
        rst = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_tx_a"}, 32'(tx_a_data), 32'h0);
        check({tag, "_tx_b"}, 32'(tx_b_data), 32'h0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, base, bbase;
        repeat (3) @(negedge clk_1M);
        rst = 1'b1;
        @(negedge clk_1M);
        check_zero("reset");

        // 1: single request, latency and busy length
        base = s_id.size();
        bbase = busy_cnt;
        drive(4'b0001, 32'h0000_00A5, 32'h0000_003C, k);
        wait_cyc(40);
        check("t1_nstarts", 32'(s_id.size() - base), 32'd1);
        check("t1_latency", 32'(qget(s_edge, base) - k), 32'd2);
        check("t1_a", 32'(qget(s_a, base)), 32'hA5);
        check("t1_b", 32'(qget(s_b, base)), 32'h3C);
        check("t1_id", 32'(qget(s_id, base)), 32'd0);
        check("t1_busy_len", 32'(busy_cnt - bbase), 32'd22);

        // 2: all four at once, served 0..3 with 23-cycle spacing
        do_reset();
        base = s_id.size();
        drive(4'b1111, 32'h4433_2211, 32'hD4C3_B2A1, k);
        wait_cyc(4 * PERIOD + 10);
        check("t2_nstarts", 32'(s_id.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_id", 32'(qget(s_id, base + i)), 32'(i));
            check("t2_a", 32'(qget(s_a, base + i)), 32'(8'h11 * (i + 1)));
            check("t2_b", 32'(qget(s_b, base + i)), 32'(8'hA1 + 8'h11 * i));
            if (i > 0)
                check("t2_spacing", 32'(qget(s_edge, base + i) - qget(s_edge, base + i - 1)), 32'd23);
        end

        // 3: double request from source 2 during source 1's frame
        do_reset();
        base = s_id.size();
        drive(4'b0010, 32'h0000_7700, 32'h0000_7800, k);
        wait_cyc(4);
        drive(4'b0100, 32'h0011_0000, 32'h0011_0000, k2);
        wait_cyc(3);
        drive(4'b0100, 32'h0022_0000, 32'h0022_0000, k2);
        check("t3_overrun_set", 32'(overrun), 32'h4);
        wait_cyc(60);
        check("t3_nstarts", 32'(s_id.size() - base), 32'd2);
        check("t3_id0", 32'(qget(s_id, base)), 32'd1);
        check("t3_a0", 32'(qget(s_a, base)), 32'h77);
        check("t3_id1", 32'(qget(s_id, base + 1)), 32'd2);
        check("t3_a1", 32'(qget(s_a, base + 1)), 32'h22);
        check("t3_b1", 32'(qget(s_b, base + 1)), 32'h22);
        @(negedge clk_1M);
        clr_ovr = 1'b1;
        @(negedge clk_1M);
        clr_ovr = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 32'h0);

        // 4: two sources re-requesting every frame alternate
        do_reset();
        base = s_id.size();
        for (int r = 0; r < 6; r++) begin
            drive(4'b0011, {16'h0, 8'(8'h20 + r), 8'(8'h10 + r)}, {16'h0, 8'(8'h60 + r), 8'(8'h50 + r)}, k);
            wait_cyc(PERIOD - 2);
        end
        wait_cyc(80);
        check("t4_nstarts_ge6", 32'(s_id.size() - base >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            check("t4_alternate", 32'(qget(s_id, base + i)), 32'(i % 2));

        // 5: request on the same edge as its own grant
        do_reset();
        base = s_id.size();
        @(negedge clk_1M);
        req = 4'b1000;
        req_a_data = 32'h3100_0000;
        req_b_data = 32'h3200_0000;
        @(negedge clk_1M);
        req_a_data = 32'h4100_0000;
        req_b_data = 32'h4200_0000;
        @(negedge clk_1M);
        req = '0;
        wait_cyc(2 * PERIOD + 10);
        check("t5_nstarts", 32'(s_id.size() - base), 32'd2);
        check("t5_id0", 32'(qget(s_id, base)), 32'd3);
        check("t5_a0", 32'(qget(s_a, base)), 32'h31);
        check("t5_b0", 32'(qget(s_b, base)), 32'h32);
        check("t5_id1", 32'(qget(s_id, base + 1)), 32'd3);
        check("t5_a1", 32'(qget(s_a, base + 1)), 32'h41);
        check("t5_b1", 32'(qget(s_b, base + 1)), 32'h42);
        check("t5_spacing", 32'(qget(s_edge, base + 1) - qget(s_edge, base)), 32'd23);
        check("t5_overrun", 32'(overrun), 32'h0);

        // 6: reset in the middle of a frame
        do_reset();
        drive(4'b0001, 32'h0000_005A, 32'h0000_00A5, k);
        wait_cyc(8);
        check("t6_busy_before", 32'(busy), 32'd1);
        @(posedge clk_1M);
        #2 rst = 1'b0;
        #1 check_zero("t6_async");
        repeat (3) @(negedge clk_1M);
        check_zero("t6_held");
        rst = 1'b1;
        base = s_id.size();
        wait_cyc(60);
        check("t6_no_start", 32'(s_id.size() - base), 32'd0);
        check_zero("t6_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
